frame_composer: RTL and testbench
=================================

Name: frame_composer

Overview:
- Parametrised successor of the Tamagotchi screen builder: produces the full RGB565 pixel stream for the LCD driver (16x16-style cell grid).
- Streams line-major, pixel by pixel: sprite area from ROM, N_BARS level bars, a health column and a mode indicator cell.
- Uses a valid/ready handshake in the system clock domain (no derived data clock), counter-based cell tracking (no dividers), and snapshots all status inputs at frame start.

Parameters:
- LINE_PIX, 220: pixels per line.
- LINES, 176: lines per frame.
- CELL, 11: pixels per cell edge, in both axes.
- SPR_COL0, 1: first sprite cell column.
- SPR_ROW0, 2: first sprite cell row.
- SPR_W, 13: sprite width in cells.
- SPR_H, 13: sprite height in cells.
- N_SPR, 8: sprites in ROM.
- BAR_COL0, 16: health column; bar i occupies column BAR_COL0+1+i.
- N_BARS, 3: number of level bars.
- BAR_LEVELS, 4: level bands per bar.
- LVL_W, 3: width of each level input.
- IND_COL, 7: mode indicator cell column (row 0).
- BG, 16'hFFFF: background colour.
- HEALTH_C, 16'hF800: health colour.
- IND_C, 16'h001F: indicator colour.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset.
- start  in  1  request one frame; sampled only in IDLE.
- auto_run  in  1  when 1, the next frame starts right after frame_done.
- sprite_sel  in  clog2(N_SPR)  sprite index.
- levels  in  N_BARS*LVL_W  packed bar levels; bar 0 in the LSBs.
- bar_colors  in  N_BARS*16  packed RGB565 colour per bar.
- healthy  in  1  health flag.
- mode  in  1  indicator enable.
- rom_addr  out  clog2(N_SPR)+clog2(SPR_W*SPR_H)  formed as {sprite, cell_index}.
- rom_data  in  16  ROM pixel; registered ROM, 1-cycle latency.
- pix_data  out  16  pixel to driver.
- pix_valid  out  1  pix_data valid.
- pix_ready  in  1  driver accepts pixel.
- frame_done  out  1  1-cycle pulse after the last pixel is accepted.
- busy  out  1  high from frame start until frame_done.

Behaviour:
- Reset (rst=0 at a clk edge): state IDLE, all counters 0, pix_valid=0, pix_data=BG, frame_done=0, busy=0, rom_addr=0. Reset mid-frame aborts immediately and emits no frame_done.
- Counters: px (0..CELL-1), cx (cell column), py (0..CELL-1), cy (cell row). px wraps and increments cx; at line end (cx*CELL+px == LINE_PIX-1) px and cx clear and py increments. The same wrap scheme applies to py/cy. Partial last cells are allowed.
- FSM states:
  - IDLE: on start or auto_run, latch snapshot (sprite_sel, levels, bar_colors, healthy, mode), clear counters, busy=1, go to FETCH.
  - FETCH: drive rom_addr = {snap_sprite, (cx-SPR_COL0) + (cy-SPR_ROW0)*SPR_W}; this cell index is valid only in the sprite area and rom_addr holds its last value otherwise. Go to WAIT.
  - WAIT: one cycle for ROM latency. Go to PRESENT.
  - PRESENT: register the selected colour into pix_data, pix_valid=1, hold pix_data stable until pix_ready. On pix_valid&&pix_ready, drop valid; if this is the last pixel, go to DONE, else advance counters and go to FETCH.
  - DONE: frame_done=1 for one cycle, busy=0, go to IDLE. An auto_run restart is taken on the following cycle.
- pix_ready while pix_valid=0 is ignored. Throughput is at most 1 pixel per 3 cycles.
- Colour select, by cell (cx,cy), in priority order:
  1. cx==IND_COL && cy==0: IND_C if mode, else BG.
  2. Sprite area (SPR_COL0 <= cx < SPR_COL0+SPR_W and SPR_ROW0 <= cy < SPR_ROW0+SPR_H): rom_data.
  3. cx==BAR_COL0: HEALTH_C if healthy; else HEALTH_C only in the bottom band; else BG.
  4. cx==BAR_COL0+1+i: band k = cy/(rows/BAR_LEVELS), k=0 at top. Lit (bar_colors[i]) iff level_i > BAR_LEVELS-1-k, else BG. Levels >= BAR_LEVELS light all bands; level 0 lights none. Band boundaries are precomputed constants; no runtime divide.
  5. Otherwise BG.
- Status inputs changing mid-frame have no effect until the next frame. start during a frame is ignored.

Decomposition:
- Package frame_pkg: RGB565 colour constants, state enum (IDLE, FETCH, WAIT, PRESENT, DONE), clog2-based width helpers.
- One sub-module, bar_painter: combinational. Inputs are cell column/row, snapshot levels/colours and healthy; outputs hit flag and colour. It holds all bar/health logic for N_BARS.

Test Plan:
- Reset during PRESENT at pixel 500 -> next cycle pix_valid=0, busy=0, no frame_done; the next start produces pixel 0 first.
- Defaults, levels={3'd4,3'd2,3'd0}, healthy=1, mode=1, pix_ready always 1:
  - exactly 38720 pixels, then one frame_done.
  - pixel (line 0, x=77) = 16'h001F.
  - bar 0 column at line 0 = BG.
  - bar 2 column at line 0 = bar_colors[2].
- healthy=0 -> health column = BG for lines 0..131, = 16'hF800 for lines 132..175.
- ROM model returning its address, sprite_sel=5 -> first sprite pixel (line 22, x=11) requests rom_addr = {3'd5, 8'd0}. Pixel at line 22, x=154 shows cell index 12.
- pix_ready randomly low 70% -> pix_data stable while valid&&!ready; stream content identical to the ready=1 run.
- levels changed mid-frame with auto_run=1 -> frame N unchanged, frame N+1 reflects the new levels; the gap between frame_done and pixel 0 of frame N+1 is at most 4 cycles.

Source files
------------

// File: rtl/frame_pkg.sv
// Shared colour constants, FSM state type and width helpers for the frame composer.
package frame_pkg;

   localparam logic [15:0] RGB_WHITE = 16'hFFFF;
   localparam logic [15:0] RGB_RED   = 16'hF800;
   localparam logic [15:0] RGB_BLUE  = 16'h001F;

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StWait,
      StPresent,
      StDone
   } state_e;

   // Bits needed to count 0..n-1; never narrower than one bit.
   function automatic int unsigned width_of(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int unsigned div_ceil(input int unsigned a, input int unsigned b);
      return (a + b - 1) / b;
   endfunction

endpackage

// File: rtl/frame_composer_bar_painter.sv
// Health column and level bars: decides whether a cell belongs to a bar and its colour.
module bar_painter
   import frame_pkg::*;
#(
   parameter int unsigned CX_W       = 5,
   parameter int unsigned CY_W       = 4,
   parameter int unsigned ROWS       = 16,
   parameter int unsigned BAR_COL0   = 16,
   parameter int unsigned N_BARS     = 3,
   parameter int unsigned BAR_LEVELS = 4,
   parameter int unsigned LVL_W      = 3,
   parameter logic [15:0] HEALTH_C   = RGB_RED,
   parameter logic [15:0] BG         = RGB_WHITE
) (
   input  logic [CX_W-1:0]         cx,
   input  logic [CY_W-1:0]         cy,
   input  logic [N_BARS*LVL_W-1:0] levels,
   input  logic [N_BARS*16-1:0]    bar_colors,
   input  logic                    healthy,
   output logic                    hit,
   output logic [15:0]             color
);

   // Rows per band; bands past the last full one fold into the bottom band.
   localparam int unsigned BAND_H = (ROWS >= BAR_LEVELS) ? ROWS / BAR_LEVELS : 1;

   int unsigned band;

   // Band index (0 = top) from constant row thresholds, no divider.
   always_comb begin
      band = 0;
      for (int unsigned j = 1; j < BAR_LEVELS; j++) begin
         if (32'(cy) >= j * BAND_H) band = j;
      end
   end

   // Health column, then per-bar fill: bar lit when level + band reaches BAR_LEVELS.
   always_comb begin
      hit   = 1'b0;
      color = BG;
      if (32'(cx) == BAR_COL0) begin
         hit = 1'b1;
         if (healthy || band == BAR_LEVELS - 1) color = HEALTH_C;
      end
      for (int unsigned i = 0; i < N_BARS; i++) begin
         if (32'(cx) == BAR_COL0 + 1 + i) begin
            hit = 1'b1;
            if (32'(levels[i*LVL_W +: LVL_W]) + band >= BAR_LEVELS) begin
               color = bar_colors[i*16 +: 16];
            end
         end
      end
   end

endmodule

// File: rtl/frame_composer.sv
// Streams one RGB565 frame (sprite, indicator, health column, level bars) over valid/ready.
module frame_composer
   import frame_pkg::*;
#(
   parameter int unsigned LINE_PIX   = 220,
   parameter int unsigned LINES      = 176,
   parameter int unsigned CELL       = 11,
   parameter int unsigned SPR_COL0   = 1,
   parameter int unsigned SPR_ROW0   = 2,
   parameter int unsigned SPR_W      = 13,
   parameter int unsigned SPR_H      = 13,
   parameter int unsigned N_SPR      = 8,
   parameter int unsigned BAR_COL0   = 16,
   parameter int unsigned N_BARS     = 3,
   parameter int unsigned BAR_LEVELS = 4,
   parameter int unsigned LVL_W      = 3,
   parameter int unsigned IND_COL    = 7,
   parameter logic [15:0] BG         = RGB_WHITE,
   parameter logic [15:0] HEALTH_C   = RGB_RED,
   parameter logic [15:0] IND_C      = RGB_BLUE,
   localparam int unsigned SEL_W     = width_of(N_SPR),
   localparam int unsigned IDX_W     = width_of(SPR_W * SPR_H),
   localparam int unsigned ADDR_W    = SEL_W + IDX_W
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    auto_run,
   input  logic [SEL_W-1:0]        sprite_sel,
   input  logic [N_BARS*LVL_W-1:0] levels,
   input  logic [N_BARS*16-1:0]    bar_colors,
   input  logic                    healthy,
   input  logic                    mode,
   output logic [ADDR_W-1:0]       rom_addr,
   input  logic [15:0]             rom_data,
   output logic [15:0]             pix_data,
   output logic                    pix_valid,
   input  logic                    pix_ready,
   output logic                    frame_done,
   output logic                    busy
);

   localparam int unsigned COLS = div_ceil(LINE_PIX, CELL);
   localparam int unsigned ROWS = div_ceil(LINES, CELL);
   localparam int unsigned PX_W = width_of(CELL);
   localparam int unsigned CX_W = width_of(COLS);
   localparam int unsigned CY_W = width_of(ROWS);

   // Position of the final pixel of a line / frame, split into cell and offset.
   localparam logic [PX_W-1:0] CELL_END = PX_W'(CELL - 1);
   localparam logic [CX_W-1:0] LAST_CX  = CX_W'((LINE_PIX - 1) / CELL);
   localparam logic [PX_W-1:0] LAST_PX  = PX_W'((LINE_PIX - 1) % CELL);
   localparam logic [CY_W-1:0] LAST_CY  = CY_W'((LINES - 1) / CELL);
   localparam logic [PX_W-1:0] LAST_PY  = PX_W'((LINES - 1) % CELL);

   state_e                    state_q;
   logic [PX_W-1:0]           px_q, px_n, py_q, py_n;
   logic [CX_W-1:0]           cx_q, cx_n;
   logic [CY_W-1:0]           cy_q, cy_n;
   logic [SEL_W-1:0]          spr_q;
   logic [N_BARS*LVL_W-1:0]   lvl_q;
   logic [N_BARS*16-1:0]      colors_q;
   logic                      healthy_q, mode_q;
   logic                      last_pix;
   logic                      bar_hit;
   logic [15:0]               bar_col, pix_sel;

   function automatic logic in_sprite(input logic [CX_W-1:0] c, input logic [CY_W-1:0] r);
      return (32'(c) >= SPR_COL0) && (32'(c) < SPR_COL0 + SPR_W) &&
             (32'(r) >= SPR_ROW0) && (32'(r) < SPR_ROW0 + SPR_H);
   endfunction

   function automatic logic [IDX_W-1:0] cell_idx(input logic [CX_W-1:0] c,
                                                 input logic [CY_W-1:0] r);
      return IDX_W'((32'(c) - SPR_COL0) + (32'(r) - SPR_ROW0) * SPR_W);
   endfunction

   // Next pixel position: px/cx wrap per cell and per line, py/cy advance at line end.
   always_comb begin
      px_n     = px_q;
      cx_n     = cx_q;
      py_n     = py_q;
      cy_n     = cy_q;
      last_pix = (cx_q == LAST_CX) && (px_q == LAST_PX) && (cy_q == LAST_CY) && (py_q == LAST_PY);
      if (cx_q == LAST_CX && px_q == LAST_PX) begin
         px_n = '0;
         cx_n = '0;
         if (py_q == CELL_END) begin
            py_n = '0;
            cy_n = cy_q + CY_W'(1);
         end else begin
            py_n = py_q + PX_W'(1);
         end
      end else if (px_q == CELL_END) begin
         px_n = '0;
         cx_n = cx_q + CX_W'(1);
      end else begin
         px_n = px_q + PX_W'(1);
      end
   end

   bar_painter #(
      .CX_W       (CX_W),
      .CY_W       (CY_W),
      .ROWS       (ROWS),
      .BAR_COL0   (BAR_COL0),
      .N_BARS     (N_BARS),
      .BAR_LEVELS (BAR_LEVELS),
      .LVL_W      (LVL_W),
      .HEALTH_C   (HEALTH_C),
      .BG         (BG)
   ) u_bar_painter (
      .cx         (cx_q),
      .cy         (cy_q),
      .levels     (lvl_q),
      .bar_colors (colors_q),
      .healthy    (healthy_q),
      .hit        (bar_hit),
      .color      (bar_col)
   );

   // Colour of the current cell in priority order: indicator, sprite, bars, background.
   always_comb begin
      pix_sel = BG;
      if (32'(cx_q) == IND_COL && cy_q == '0) begin
         pix_sel = mode_q ? IND_C : BG;
      end else if (in_sprite(cx_q, cy_q)) begin
         pix_sel = rom_data;
      end else if (bar_hit) begin
         pix_sel = bar_col;
      end
   end

   // Frame FSM; rom_addr is loaded on entry to FETCH so the ROM word lands in WAIT.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= StIdle;
         px_q       <= '0;
         cx_q       <= '0;
         py_q       <= '0;
         cy_q       <= '0;
         spr_q      <= '0;
         lvl_q      <= '0;
         colors_q   <= '0;
         healthy_q  <= 1'b0;
         mode_q     <= 1'b0;
         rom_addr   <= '0;
         pix_data   <= BG;
         pix_valid  <= 1'b0;
         frame_done <= 1'b0;
         busy       <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start || auto_run) begin
                  spr_q     <= sprite_sel;
                  lvl_q     <= levels;
                  colors_q  <= bar_colors;
                  healthy_q <= healthy;
                  mode_q    <= mode;
                  px_q      <= '0;
                  cx_q      <= '0;
                  py_q      <= '0;
                  cy_q      <= '0;
                  busy      <= 1'b1;
                  if (in_sprite('0, '0)) rom_addr <= {sprite_sel, cell_idx('0, '0)};
                  state_q   <= StFetch;
               end
            end
            StFetch: state_q <= StWait;
            StWait: begin
               pix_data  <= pix_sel;
               pix_valid <= 1'b1;
               state_q   <= StPresent;
            end
            StPresent: begin
               if (pix_valid && pix_ready) begin
                  pix_valid <= 1'b0;
                  if (last_pix) begin
                     frame_done <= 1'b1;
                     busy       <= 1'b0;
                     state_q    <= StDone;
                  end else begin
                     px_q    <= px_n;
                     cx_q    <= cx_n;
                     py_q    <= py_n;
                     cy_q    <= cy_n;
                     if (in_sprite(cx_n, cy_n)) rom_addr <= {spr_q, cell_idx(cx_n, cy_n)};
                     state_q <= StFetch;
                  end
               end
            end
            StDone:  state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_frame_composer.sv
// Randomised bench for frame_composer on a reduced geometry with partial last cells.
module tb_frame_composer;

   localparam int W    = 39;
   localparam int H    = 31;
   localparam int C    = 2;
   localparam int NPIX = W * H;
   localparam int ROWS = (H + C - 1) / C;
   localparam logic [15:0] BGC  = 16'hFFFF;
   localparam logic [15:0] HLTH = 16'hF800;
   localparam logic [15:0] INDC = 16'h001F;

   typedef struct {
      logic [2:0]  spr;
      logic [8:0]  lv;
      logic [47:0] col;
      logic        h;
      logic        m;
   } cfg_t;

   logic        clk, rst, start, auto_run, healthy, mode, pix_ready;
   logic [2:0]  sprite_sel;
   logic [8:0]  levels;
   logic [47:0] bar_colors;
   logic [10:0] rom_addr;
   logic [15:0] rom_data, pix_data;
   logic        pix_valid, frame_done, busy;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   logic [15:0] got_pix[$];
   logic [10:0] got_addr[$];
   logic [15:0] ref_pix[$];
   int unstable, busy_bad, done_seen, t_first, t_done;

   frame_composer #(
      .LINE_PIX (W),
      .LINES    (H),
      .CELL     (C)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .auto_run   (auto_run),
      .sprite_sel (sprite_sel),
      .levels     (levels),
      .bar_colors (bar_colors),
      .healthy    (healthy),
      .mode       (mode),
      .rom_addr   (rom_addr),
      .rom_data   (rom_data),
      .pix_data   (pix_data),
      .pix_valid  (pix_valid),
      .pix_ready  (pix_ready),
      .frame_done (frame_done),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Registered ROM whose contents equal the address.
   always @(posedge clk) rom_data <= {5'd0, rom_addr};

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Expected pixel straight from cell geometry rules.
   function automatic logic [15:0] model_pix(input int x, input int y, input cfg_t c);
      int cx, cy, band, lvl, b;
      cx   = x / C;
      cy   = y / C;
      band = cy / (ROWS / 4);
      if (band > 3) band = 3;
      if (cx == 7 && cy == 0) return c.m ? INDC : BGC;
      if (cx >= 1 && cx < 14 && cy >= 2 && cy < 15)
         return {5'd0, c.spr, 8'((cy - 2) * 13 + (cx - 1))};
      if (cx == 16) return (c.h || band == 3) ? HLTH : BGC;
      if (cx >= 17 && cx <= 19) begin
         b   = cx - 17;
         lvl = int'(c.lv[b*3 +: 3]);
         return (lvl > 3 - band) ? c.col[b*16 +: 16] : BGC;
      end
      return BGC;
   endfunction

   function automatic int pidx(input int line, input int x);
      return line * W + x;
   endfunction

   function automatic cfg_t rand_cfg();
      cfg_t c;
      c.spr = 3'($urandom_range(7));
      c.lv  = 9'($urandom);
      c.col = {16'($urandom), 16'($urandom), 16'($urandom)};
      c.h   = 1'($urandom);
      c.m   = 1'($urandom);
      return c;
   endfunction

   task automatic apply_cfg(input cfg_t c);
      sprite_sel = c.spr;
      levels     = c.lv;
      bar_colors = c.col;
      healthy    = c.h;
      mode       = c.m;
   endtask

   task automatic kick();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Collect one frame; optionally abort with reset or change inputs at a pixel index.
   task automatic run_frame(input int low_pct, input int abort_at, input int chg_at,
                            input logic [8:0] chg_lv, input logic chg_auto);
      logic        held;
      logic [15:0] held_val;
      int          n;
      got_pix.delete();
      got_addr.delete();
      unstable  = 0;
      busy_bad  = 0;
      done_seen = 0;
      t_first   = -1;
      held      = 1'b0;
      held_val  = '0;
      n         = 0;
      for (int k = 0; k < 20000; k++) begin
         @(posedge clk); #1;
         if (frame_done) begin
            done_seen = 1;
            t_done    = cyc;
            break;
         end
         if (pix_valid && t_first < 0) t_first = cyc;
         if (pix_valid && !busy) busy_bad++;
         if (pix_valid && n == abort_at) begin
            rst = 1'b0;
            return;
         end
         if (pix_valid && n == chg_at) begin
            levels   = chg_lv;
            auto_run = chg_auto;
         end
         pix_ready = ($urandom_range(99) >= low_pct);
         if (pix_valid) begin
            if (held && pix_data !== held_val) unstable++;
            if (pix_ready) begin
               got_pix.push_back(pix_data);
               got_addr.push_back(rom_addr);
               n++;
               held = 1'b0;
            end else begin
               held     = 1'b1;
               held_val = pix_data;
            end
         end
      end
   endtask

   task automatic check_frame(input string tag, input cfg_t c);
      int bad;
      check({tag, "_done"}, 64'(done_seen), 64'd1);
      check({tag, "_count"}, 64'(got_pix.size()), 64'(NPIX));
      bad = 0;
      foreach (got_pix[i]) if (got_pix[i] !== model_pix(i % W, i / W, c)) bad++;
      check({tag, "_bad_pixels"}, 64'(bad), 64'd0);
      check({tag, "_unstable"}, 64'(unstable), 64'd0);
      check({tag, "_busy"}, 64'(busy_bad), 64'd0);
   endtask

   task automatic check_after_done(input string tag);
      @(posedge clk); #1;
      check({tag, "_done_pulse"}, 64'(frame_done), 64'd0);
      check({tag, "_idle_busy"}, 64'(busy), 64'd0);
   endtask

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      cfg_t ca, cc, cd, ce, cg;
      logic [8:0] new_lv;
      int diff, gap_start, gap, extra;

      rst = 1'b0; start = 1'b0; auto_run = 1'b0; pix_ready = 1'b1;
      sprite_sel = '0; levels = '0; bar_colors = '0; healthy = 1'b0; mode = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", 64'(pix_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(frame_done), 64'd0);
      check("rst_pix_data", 64'(pix_data), 64'(BGC));
      check("rst_rom_addr", 64'(rom_addr), 64'd0);
      rst = 1'b1;
      @(posedge clk); #1;

      // Nominal frame, driver always ready.
      ca.spr = 3'd5; ca.lv = {3'd4, 3'd2, 3'd0};
      ca.col = {16'($urandom), 16'($urandom), 16'($urandom)};
      ca.h = 1'b1; ca.m = 1'b1;
      apply_cfg(ca);
      kick();
      run_frame(0, -1, -1, '0, 1'b0);
      check_frame("a", ca);
      check("a_indicator", 64'(got_pix[pidx(0, 14)]), 64'(INDC));
      check("a_bar0_line0", 64'(got_pix[pidx(0, 34)]), 64'(BGC));
      check("a_bar2_line0", 64'(got_pix[pidx(0, 38)]), 64'(ca.col[47:32]));
      check("a_rom_first", 64'(got_addr[pidx(4, 2)]), 64'({3'd5, 8'd0}));
      check("a_rom_hold", 64'(got_addr[pidx(4, 28)]), 64'({3'd5, 8'd12}));
      check("a_spr_last_cell", 64'(got_pix[pidx(4, 26)]), 64'h050C);
      check("a_after_spr_bg", 64'(got_pix[pidx(4, 28)]), 64'(BGC));
      ref_pix = got_pix;
      check_after_done("a");

      // Same content under heavy back-pressure.
      kick();
      run_frame(70, -1, -1, '0, 1'b0);
      check_frame("b", ca);
      diff = 0;
      foreach (ref_pix[i]) if (i >= got_pix.size() || got_pix[i] !== ref_pix[i]) diff++;
      check("b_same_as_ready1", 64'(diff), 64'd0);
      check_after_done("b");

      // Unhealthy, indicator off; status inputs scrambled mid-frame must not matter.
      cc = rand_cfg(); cc.h = 1'b0; cc.m = 1'b0;
      apply_cfg(cc);
      kick();
      healthy = 1'b1; mode = 1'b1; sprite_sel = ~cc.spr; bar_colors = ~cc.col;
      run_frame(20, -1, 200, ~cc.lv, 1'b0);
      check_frame("c", cc);
      check("c_health_top", 64'(got_pix[pidx(23, 32)]), 64'(BGC));
      check("c_health_bottom", 64'(got_pix[pidx(24, 32)]), 64'(HLTH));
      check("c_indicator_off", 64'(got_pix[pidx(0, 14)]), 64'(BGC));
      check_after_done("c");

      // Auto-run: levels changed during frame N show up only in frame N+1.
      cd = rand_cfg();
      new_lv = ~cd.lv;
      apply_cfg(cd);
      auto_run = 1'b1;
      run_frame(10, -1, 300, new_lv, 1'b1);
      check_frame("d_n", cd);
      gap_start = t_done;
      ce = cd; ce.lv = new_lv;
      run_frame(10, -1, 10, new_lv, 1'b0);
      gap = t_first - gap_start;
      check("d_gap_le4", 64'(gap >= 1 && gap <= 4), 64'd1);
      check_frame("d_n1", ce);
      extra = 0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk); #1;
         if (pix_valid || busy) extra++;
      end
      check("d_no_third_frame", 64'(extra), 64'd0);

      // Reset while pixel 500 is presented, then a clean restart.
      cg = rand_cfg();
      apply_cfg(cg);
      kick();
      run_frame(0, 500, -1, '0, 1'b0);
      @(posedge clk); #1;
      check("e_abort_valid", 64'(pix_valid), 64'd0);
      check("e_abort_busy", 64'(busy), 64'd0);
      check("e_abort_done", 64'(frame_done), 64'd0);
      rst = 1'b1;
      extra = 0;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk); #1;
         if (frame_done || busy) extra++;
      end
      check("e_no_done_after_abort", 64'(extra), 64'd0);
      cg = rand_cfg();
      apply_cfg(cg);
      kick();
      run_frame(30, -1, -1, '0, 1'b0);
      check_frame("e_restart", cg);
      check_after_done("e");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
